// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: GPR/HILO forwarding, load-use and
// branch stalls, multi-cycle divider stall FSM, exception flush and a stall-cycle counter.
module hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int DIV_CYCLES   = 32,
   parameter int BRANCH_STALL = 1,
   parameter int PERF_W       = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic              branchD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic              regwriteE,
   input  logic              memtoregE,
   input  logic              divE,
   input  logic [REG_AW-1:0] writeregM,
   input  logic              regwriteM,
   input  logic              memtoregM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteW,
   input  logic [2:0]        flagE,
   input  logic [2:0]        flagM,
   input  logic [2:0]        flagW,
   input  logic              exc_flush,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              forwardaD,
   output logic              forwardbD,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic              div_start,
   output logic              div_done,
   output logic [PERF_W-1:0] stall_cnt
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } div_state_t;

   div_state_t        state, state_nx;
   logic [CW-1:0]     cnt, cnt_nx;
   logic [1:0]        fwd_a_gpr, fwd_b_gpr;
   logic              hilo_rd;
   logic              lwstall, brstall, br_e_hit, br_m_hit, divbusy;

   // Only the read side of a HILO access consumes a forwarded value.
   logic unused_flag_bits;
   assign unused_flag_bits = ^{flagM[2], flagW[2]};

   always_comb begin
      fwd_a_gpr = 2'b00;
      fwd_b_gpr = 2'b00;
      if (rsE != '0 && rsE == writeregM && regwriteM)      fwd_a_gpr = 2'b10;
      else if (rsE != '0 && rsE == writeregW && regwriteW) fwd_a_gpr = 2'b01;
      if (rtE != '0 && rtE == writeregM && regwriteM)      fwd_b_gpr = 2'b10;
      else if (rtE != '0 && rtE == writeregW && regwriteW) fwd_b_gpr = 2'b01;

      hilo_rd   = (flagE != 3'b000) && !flagE[2];
      forwardaE = fwd_a_gpr;
      if (hilo_rd && flagE[1:0] == flagM[1:0])      forwardaE = 2'b10;
      else if (hilo_rd && flagE[1:0] == flagW[1:0]) forwardaE = 2'b01;
      forwardbE = fwd_b_gpr;
   end

   assign forwardaD = (rsD != '0) && (rsD == writeregM) && regwriteM;
   assign forwardbD = (rtD != '0) && (rtD == writeregM) && regwriteM;

   assign lwstall  = memtoregE && (rtE == rsD || rtE == rtD);
   assign br_e_hit = regwriteE && (writeregE != '0) && (writeregE == rsD || writeregE == rtD);
   assign br_m_hit = memtoregM && (writeregM != '0) && (writeregM == rsD || writeregM == rtD);
   assign brstall  = (BRANCH_STALL != 0) && branchD && (br_e_hit || br_m_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      div_start = 1'b0;
      div_done  = 1'b0;
      case (state)
         IDLE: begin
            if (divE && !exc_flush) begin
               div_start = 1'b1;
               state_nx  = BUSY;
               cnt_nx    = CW'(DIV_CYCLES - 1);
            end
         end
         BUSY: begin
            if (cnt == '0) state_nx = DONE;
            else           cnt_nx   = cnt - CW'(1);
         end
         DONE: begin
            div_done = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      // An exception aborts the divide outright; its result is never reported.
      if (exc_flush) begin
         state_nx = IDLE;
         cnt_nx   = '0;
         div_done = 1'b0;
      end
   end

   assign divbusy = div_start || (state == BUSY);

   always_comb begin
      stallF = 1'b0;
      stallD = 1'b0;
      stallE = 1'b0;
      flushD = 1'b0;
      flushE = 1'b0;
      flushM = 1'b0;
      if (exc_flush) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
      end else if (divbusy) begin
         stallF = 1'b1;
         stallD = 1'b1;
         stallE = 1'b1;
         flushM = 1'b1;
      end else if (lwstall || brstall) begin
         stallF = 1'b1;
         stallD = 1'b1;
         flushE = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         stall_cnt <= '0;
      else if (stallF) stall_cnt <= stall_cnt + PERF_W'(1);
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed vector table, divider/abort/reset
// sequences and randomized stimulus against a cycle-age reference model.
module tb_hazard_ctrl;

   localparam int AW   = 5;
   localparam int DIVC = 4;
   localparam int PW   = 32;

   typedef struct packed {
      logic [AW-1:0] rsD;
      logic [AW-1:0] rtD;
      logic          branchD;
      logic [AW-1:0] rsE;
      logic [AW-1:0] rtE;
      logic [AW-1:0] writeregE;
      logic          regwriteE;
      logic          memtoregE;
      logic          divE;
      logic [AW-1:0] writeregM;
      logic          regwriteM;
      logic          memtoregM;
      logic [AW-1:0] writeregW;
      logic          regwriteW;
      logic [2:0]    flagE;
      logic [2:0]    flagM;
      logic [2:0]    flagW;
      logic          exc;
   } in_t;

   typedef struct {
      string       name;
      in_t         i;
      logic [13:0] e;
      logic [13:0] e_nb;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   in_t  vin;

   always #5 clk = ~clk;

   logic          stallF, stallD, stallE, flushD, flushE, flushM;
   logic          forwardaD, forwardbD, div_start, div_done;
   logic [1:0]    forwardaE, forwardbE;
   logic [PW-1:0] stall_cnt;
   logic          n_stallF, n_stallD, n_stallE, n_flushD, n_flushE, n_flushM;
   logic          n_forwardaD, n_forwardbD, n_div_start, n_div_done;
   logic [1:0]    n_forwardaE, n_forwardbE;
   logic [PW-1:0] n_stall_cnt;

   hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DIVC), .BRANCH_STALL(1), .PERF_W(PW)) dut (
      .clk(clk), .rst(rst), .rsD(vin.rsD), .rtD(vin.rtD), .branchD(vin.branchD),
      .rsE(vin.rsE), .rtE(vin.rtE), .writeregE(vin.writeregE), .regwriteE(vin.regwriteE),
      .memtoregE(vin.memtoregE), .divE(vin.divE), .writeregM(vin.writeregM),
      .regwriteM(vin.regwriteM), .memtoregM(vin.memtoregM), .writeregW(vin.writeregW),
      .regwriteW(vin.regwriteW), .flagE(vin.flagE), .flagM(vin.flagM), .flagW(vin.flagW),
      .exc_flush(vin.exc), .stallF(stallF), .stallD(stallD), .stallE(stallE),
      .flushD(flushD), .flushE(flushE), .flushM(flushM), .forwardaD(forwardaD),
      .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
      .div_start(div_start), .div_done(div_done), .stall_cnt(stall_cnt)
   );

   hazard_ctrl #(.REG_AW(AW), .DIV_CYCLES(DIVC), .BRANCH_STALL(0), .PERF_W(PW)) dut_nb (
      .clk(clk), .rst(rst), .rsD(vin.rsD), .rtD(vin.rtD), .branchD(vin.branchD),
      .rsE(vin.rsE), .rtE(vin.rtE), .writeregE(vin.writeregE), .regwriteE(vin.regwriteE),
      .memtoregE(vin.memtoregE), .divE(vin.divE), .writeregM(vin.writeregM),
      .regwriteM(vin.regwriteM), .memtoregM(vin.memtoregM), .writeregW(vin.writeregW),
      .regwriteW(vin.regwriteW), .flagE(vin.flagE), .flagM(vin.flagM), .flagW(vin.flagW),
      .exc_flush(vin.exc), .stallF(n_stallF), .stallD(n_stallD), .stallE(n_stallE),
      .flushD(n_flushD), .flushE(n_flushE), .flushM(n_flushM), .forwardaD(n_forwardaD),
      .forwardbD(n_forwardbD), .forwardaE(n_forwardaE), .forwardbE(n_forwardbE),
      .div_start(n_div_start), .div_done(n_div_done), .stall_cnt(n_stall_cnt)
   );

   logic [13:0] act, act_nb;
   assign act    = {stallF, stallD, stallE, flushD, flushE, flushM, forwardaD, forwardbD,
                    forwardaE, forwardbE, div_start, div_done};
   assign act_nb = {n_stallF, n_stallD, n_stallE, n_flushD, n_flushE, n_flushM, n_forwardaD,
                    n_forwardbD, n_forwardaE, n_forwardbE, n_div_start, n_div_done};

   int            checks = 0;
   int            failures = 0;
   int            age;        // 0 idle, 1..DIVC cycles into the divide, DIVC+1 result cycle
   logic [PW-1:0] m_cnt, m_cnt_nb;
   vec_t          vecs[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [13:0] pk(input bit sf, sd, se, fd, fe, fm, fad, fbd,
                                      input logic [1:0] fae, fbe, input bit ds, dd);
      return {sf, sd, se, fd, fe, fm, fad, fbd, fae, fbe, ds, dd};
   endfunction

   function automatic logic [1:0] gpr_src(input in_t v, input logic [AW-1:0] src);
      if (src != 0 && src == v.writeregM && v.regwriteM) return 2'd2;
      if (src != 0 && src == v.writeregW && v.regwriteW) return 2'd1;
      return 2'd0;
   endfunction

   function automatic logic [13:0] model(input in_t v, input int a, input bit br_en);
      bit idle = (a == 0);
      bit busy = (a >= 1 && a <= DIVC);
      bit done = (a == DIVC + 1);
      bit ds   = idle && v.divE && !v.exc;
      bit dd   = done && !v.exc;
      bit lw   = v.memtoregE && (v.rtE == v.rsD || v.rtE == v.rtD);
      bit br   = br_en && v.branchD &&
                 ((v.regwriteE && v.writeregE != 0 && (v.writeregE == v.rsD || v.writeregE == v.rtD)) ||
                  (v.memtoregM && v.writeregM != 0 && (v.writeregM == v.rsD || v.writeregM == v.rtD)));
      bit sf = 0, sd = 0, se = 0, fd = 0, fe = 0, fm = 0;
      logic [1:0] fae = gpr_src(v, v.rsE);
      logic [1:0] fbe = gpr_src(v, v.rtE);
      if (v.exc) begin
         fd = 1; fe = 1; fm = 1;
      end else if (ds || busy) begin
         sf = 1; sd = 1; se = 1; fm = 1;
      end else if (lw || br) begin
         sf = 1; sd = 1; fe = 1;
      end
      if (v.flagE != 0 && !v.flagE[2]) begin
         if (v.flagE[1:0] == v.flagM[1:0])      fae = 2'd2;
         else if (v.flagE[1:0] == v.flagW[1:0]) fae = 2'd1;
      end
      return pk(sf, sd, se, fd, fe, fm,
                v.rsD != 0 && v.rsD == v.writeregM && v.regwriteM,
                v.rtD != 0 && v.rtD == v.writeregM && v.regwriteM, fae, fbe, ds, dd);
   endfunction

   function automatic int next_age(input in_t v, input int a);
      if (v.exc) return 0;
      if (a == 0) return v.divE ? 1 : 0;
      if (a <= DIVC) return a + 1;
      return 0;
   endfunction

   task automatic apply(input in_t v);
      vin = v;
      @(negedge clk);
   endtask

   task automatic check_model(input string tag);
      chk({tag, "_out"}, act, model(vin, age, 1));
      chk({tag, "_out_nb"}, act_nb, model(vin, age, 0));
      chk({tag, "_cnt"}, stall_cnt, m_cnt);
      chk({tag, "_cnt_nb"}, n_stall_cnt, m_cnt_nb);
   endtask

   task automatic advance();
      logic [13:0] m, mn;
      m  = model(vin, age, 1);
      mn = model(vin, age, 0);
      if (m[13])  m_cnt    = m_cnt + 1;
      if (mn[13]) m_cnt_nb = m_cnt_nb + 1;
      age = next_age(vin, age);
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string n, input in_t v, input logic [13:0] e, input logic [13:0] enb);
      vec_t t;
      t.name = n; t.i = v; t.e = e; t.e_nb = enb;
      vecs.push_back(t);
   endtask

   initial begin
      in_t v;
      logic [PW-1:0] base;

      rst = 1'b1;
      vin = '0;
      age = 0;
      m_cnt = '0;
      m_cnt_nb = '0;
      @(negedge clk);
      chk("reset_out", act, 14'd0);
      chk("reset_out_nb", act_nb, 14'd0);
      chk("reset_cnt", stall_cnt, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      v = '0; add_vec("zero", v, 14'd0, 14'd0);
      v = '0; v.memtoregE = 1; v.rtE = 5; v.rsD = 5;
      add_vec("loaduse", v, pk(1,1,0,0,1,0,0,0,0,0,0,0), pk(1,1,0,0,1,0,0,0,0,0,0,0));
      v = '0; v.rsE = 3; v.writeregM = 3; v.regwriteM = 1; v.writeregW = 3; v.regwriteW = 1;
      add_vec("fwd_prio", v, pk(0,0,0,0,0,0,0,0,2,0,0,0), pk(0,0,0,0,0,0,0,0,2,0,0,0));
      v.rsE = 0;
      add_vec("fwd_r0", v, 14'd0, 14'd0);
      v = '0; v.rtE = 6; v.writeregW = 6; v.regwriteW = 1;
      add_vec("fwd_b_w", v, pk(0,0,0,0,0,0,0,0,0,1,0,0), pk(0,0,0,0,0,0,0,0,0,1,0,0));
      v = '0; v.flagE = 3'b001; v.flagM = 3'b001;
      add_vec("hilo_m", v, pk(0,0,0,0,0,0,0,0,2,0,0,0), pk(0,0,0,0,0,0,0,0,2,0,0,0));
      v = '0; v.flagE = 3'b010; v.flagM = 3'b001; v.flagW = 3'b010;
      add_vec("hilo_w", v, pk(0,0,0,0,0,0,0,0,1,0,0,0), pk(0,0,0,0,0,0,0,0,1,0,0,0));
      v = '0; v.flagE = 3'b101; v.flagM = 3'b001;
      add_vec("hilo_wrside", v, 14'd0, 14'd0);
      v = '0; v.flagE = 3'b001; v.flagM = 3'b001; v.rsE = 3; v.writeregW = 3; v.regwriteW = 1;
      add_vec("hilo_over_gpr", v, pk(0,0,0,0,0,0,0,0,2,0,0,0), pk(0,0,0,0,0,0,0,0,2,0,0,0));
      v = '0; v.rsD = 4; v.rtD = 4; v.writeregM = 4; v.regwriteM = 1;
      add_vec("fwd_d", v, pk(0,0,0,0,0,0,1,1,0,0,0,0), pk(0,0,0,0,0,0,1,1,0,0,0,0));
      v = '0; v.branchD = 1; v.rsD = 7; v.regwriteE = 1; v.writeregE = 7;
      add_vec("branch_e", v, pk(1,1,0,0,1,0,0,0,0,0,0,0), 14'd0);
      v = '0; v.branchD = 1; v.rtD = 9; v.memtoregM = 1; v.writeregM = 9;
      add_vec("branch_m", v, pk(1,1,0,0,1,0,0,0,0,0,0,0), 14'd0);
      v = '0; v.exc = 1; v.memtoregE = 1; v.rtE = 5; v.rsD = 5;
      add_vec("exc", v, pk(0,0,0,1,1,1,0,0,0,0,0,0), pk(0,0,0,1,1,1,0,0,0,0,0,0));

      foreach (vecs[k]) begin
         apply(vecs[k].i);
         chk(vecs[k].name, act, vecs[k].e);
         chk({vecs[k].name, "_nb"}, act_nb, vecs[k].e_nb);
         if (k == 1) chk("loaduse_cnt_before", stall_cnt, 0);
         advance();
         if (k == 1) chk("loaduse_cnt_after", stall_cnt, 1);
      end
      chk("table_cnt", stall_cnt, 3);
      chk("table_cnt_nb", n_stall_cnt, 1);

      // Divider held in E, then a back-to-back second divide.
      base = m_cnt;
      for (int c = 0; c <= 6; c++) begin
         v = '0; v.divE = 1;
         apply(v);
         check_model($sformatf("div_c%0d", c));
         chk($sformatf("div_start_c%0d", c), div_start, (c == 0 || c == 6));
         chk($sformatf("div_stallE_c%0d", c), stallE, (c <= 4 || c == 6));
         chk($sformatf("div_flushM_c%0d", c), flushM, (c <= 4 || c == 6));
         chk($sformatf("div_done_c%0d", c), div_done, (c == 5));
         advance();
         if (c == 5) chk("div_cnt", stall_cnt, base + 5);
      end
      for (int c = 0; c < 6; c++) begin
         apply('0);
         check_model("div_drain");
      advance();
      end

      // Exception during a divide.
      for (int c = 0; c <= 9; c++) begin
         v = '0;
         v.divE = (c <= 2 || c == 9);
         v.exc  = (c == 2);
         apply(v);
         check_model($sformatf("abort_c%0d", c));
         if (c == 2) begin
            chk("abort_flush", {flushD, flushE, flushM}, 3'b111);
            chk("abort_nostall", stallF, 0);
         end
         if (c == 3) chk("abort_idle", stallF, 0);
         if (c >= 2 && c <= 8) chk($sformatf("abort_nodone_c%0d", c), div_done, 0);
         if (c == 9) chk("abort_restart", div_start, 1);
         advance();
      end
      for (int c = 0; c < 6; c++) begin
         apply('0);
         check_model("abort_drain");
         advance();
      end

      // Exception coincident with a new divide in IDLE.
      v = '0; v.divE = 1; v.exc = 1;
      apply(v);
      chk("exc_div_start", div_start, 0);
      chk("exc_div_stall", stallF, 0);
      advance();
      apply('0);
      chk("exc_div_after", stallF, 0);
      check_model("exc_div");
      advance();

      // Asynchronous reset in the middle of a divide.
      v = '0; v.divE = 1;
      apply(v);
      advance();
      apply('0);
      chk("rst_pre_stall", stallF, 1);
      #2 rst = 1'b1;
      #1;
      chk("rst_stallF", stallF, 0);
      chk("rst_stallE", stallE, 0);
      chk("rst_cnt", stall_cnt, 0);
      age = 0;
      m_cnt = '0;
      m_cnt_nb = '0;
      #1 rst = 1'b0;
      advance();
      apply('0);
      check_model("rst_after");
      advance();

      for (int n = 0; n < 400; n++) begin
         v.rsD       = AW'($urandom_range(0, 3));
         v.rtD       = AW'($urandom_range(0, 3));
         v.branchD   = 1'($urandom_range(0, 1));
         v.rsE       = AW'($urandom_range(0, 3));
         v.rtE       = AW'($urandom_range(0, 3));
         v.writeregE = AW'($urandom_range(0, 3));
         v.regwriteE = 1'($urandom_range(0, 1));
         v.memtoregE = ($urandom_range(0, 3) == 0);
         v.divE      = ($urandom_range(0, 5) == 0);
         v.writeregM = AW'($urandom_range(0, 3));
         v.regwriteM = 1'($urandom_range(0, 1));
         v.memtoregM = 1'($urandom_range(0, 1));
         v.writeregW = AW'($urandom_range(0, 3));
         v.regwriteW = 1'($urandom_range(0, 1));
         v.flagE     = 3'($urandom_range(0, 7));
         v.flagM     = 3'($urandom_range(0, 7));
         v.flagW     = 3'($urandom_range(0, 7));
         v.exc       = ($urandom_range(0, 11) == 0);
         apply(v);
         check_model($sformatf("rand%0d", n));
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage MIPS pipeline. It supersedes the combinational forwarding/stall logic with a unit that also covers:
- a multi-cycle divider, through a stall state machine;
- optional branch-compare stalls;
- exception flushes that abort in-flight operations;
- a stall-cycle performance counter.

It sits beside the datapath and drives the F/D/E/M enable and flush controls and all forwarding muxes.

## Interface
Parameters:
- REG_AW, 5, register address width
- DIV_CYCLES, 32, divider iteration count (≥2)
- BRANCH_STALL, 1, 1 = stall D for branch operands not yet forwardable; 0 = no branch stall
- PERF_W, 32, stall counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rsD, rtD  in  REG_AW  decode source registers
- branchD  in  1  branch in decode
- rsE, rtE, writeregE  in  REG_AW  execute sources / destination
- regwriteE, memtoregE  in  1  execute write-enable / load
- divE  in  1  div/divu in execute
- writeregM  in  REG_AW  memory destination
- regwriteM, memtoregM  in  1  memory write-enable / load
- writeregW  in  REG_AW  writeback destination
- regwriteW  in  1  writeback write-enable
- flagE, flagM, flagW  in  3  HILO access flags: [1:0] select, [2] = write-side
- exc_flush  in  1  exception/eret flush request
- stallF, stallD, stallE  out  1  hold stage register
- flushD, flushE, flushM  out  1  clear stage register to bubble
- forwardaD, forwardbD  out  1  branch comparator operand from M
- forwardaE, forwardbE  out  2  00 regfile, 01 from W, 10 from M
- div_start  out  1  start pulse to divider
- div_done  out  1  divider result valid this cycle
- stall_cnt  out  PERF_W  total cycles with stallF=1

## Operation
Forwarding (combinational, register 0 never forwarded):
- forwardaE follows HILO rules first:
  - flagE==000: 00.
  - Otherwise, if flagE[2]==0, forward from M when flagE[1:0]==flagM[1:0] (10).
  - Otherwise, under the same read condition, forward from W when flagE[1:0]==flagW[1:0] (01).
- After HILO, forwardaE and forwardbE use the GPR rule: M match with regwriteM → 10; else W match with regwriteW → 01; else 00.
- forwardaD = rsD≠0 & rsD==writeregM & regwriteM; forwardbD likewise for rtD.

Hazard sources:
- Load-use: lwstall = memtoregE & (rtE==rsD | rtE==rtD).
- Branch: brstall = BRANCH_STALL & branchD & either condition holds:
  - regwriteE & writeregE∈{rsD,rtD}, writeregE≠0;
  - memtoregM & writeregM∈{rsD,rtD}, writeregM≠0.

Divider FSM. State encodings are IDLE, BUSY, DONE; cnt is $clog2(DIV_CYCLES+1) bits.
- IDLE: div_start = divE & ~exc_flush. On div_start, go to BUSY with cnt=DIV_CYCLES-1.
- BUSY: cnt decrements each cycle. When cnt==0, go to DONE.
- DONE: div_done=1. Next state is IDLE.
- divbusy = (IDLE & div_start) | BUSY.

Control priority (highest first):
1. exc_flush:
   - flushD=flushE=flushM=1.
   - All stalls 0.
   - FSM forced to IDLE.
   - Abort is synchronous at the next edge.
2. divbusy:
   - stallF=stallD=stallE=1, flushM=1 (a bubble enters M).
   - lwstall and brstall are ignored; the E instruction is a div, so there is no load in E.
3. lwstall | brstall: stallF=stallD=1, flushE=1.
4. None of the above: all 0.

stall_cnt increments by 1 on every clock edge where stallF=1. It wraps at 2^PERF_W.

## Timing
- Reset values:
  - FSM IDLE, cnt 0, stall_cnt 0.
  - With inputs at 0, every output is 0.
- Forwarding, stall, flush and div_start are combinational in the same cycle. Only the FSM and stall_cnt are registered.
- A div entering E at cycle t (state IDLE):
  - div_start=1 and stalls are high at t.
  - BUSY spans t+1 … t+DIV_CYCLES.
  - DONE is at t+DIV_CYCLES+1, with stalls low and div_done=1; the div leaves E at that edge.
  - Total stalled cycles: DIV_CYCLES+1.
- Back-to-back divs: the second div sees IDLE the cycle after DONE and starts normally. DONE never restarts the FSM, even though divE is still 1.
- exc_flush during BUSY or DONE: the next state is IDLE, div_done is not asserted, and no stall occurs in that cycle.
- exc_flush coincident with divE in IDLE: div_start=0.
- Async rst mid-BUSY: the FSM and stall_cnt clear immediately, and all stalls drop.
- stall_cnt reflects cycles up to and including the previous edge (registered count).

## Test plan
- **Load-use:** memtoregE=1, rtE=5, rsD=5 → stallF=stallD=flushE=1 for 1 cycle; stall_cnt goes 0→1.
- **Forwarding priority:** rsE=3, writeregM=3/regwriteM=1, writeregW=3/regwriteW=1 → forwardaE=10. With rsE=0 and the same M/W matches → forwardaE=00. With flagE=001, flagM=001 → forwardaE=10.
- **Divider:** DIV_CYCLES=4, divE held 1 from cycle 0 → div_start at cycle 0 only; stallE=1 and flushM=1 cycles 0–4; div_done=1 at cycle 5; stall_cnt=5 after cycle 5's edge.
- **Abort:** during a divider run, exc_flush=1 at cycle 2 → flushD/E/M=1 in cycle 2; state IDLE at cycle 3; no div_done ever.
- **Branch mode:** branchD=1, rsD=7, regwriteE=1, writeregE=7 → stallD=1 and flushE=1 with BRANCH_STALL=1; all 0 with BRANCH_STALL=0.
- **Reset:** async rst pulse mid-BUSY, asserted between edges → stalls drop immediately; stall_cnt=0.
